pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the fetch stage. It is the registered, handshaked successor of the combinational PC+4 adder. It holds the PC, advances it by the instruction step on each accepted fetch, and takes branch/jump redirects and trap vectors with fixed priority. Misaligned targets are detected and stop fetch. It sits between the control/branch unit and instruction memory.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset (XLEN bits)
STEP, 4, byte increment per accepted fetch
CNT_W, 32, width of the fetch counter

Ports:
clk  input  1  clock; all state updates on the rising edge
resetN  input  1  asynchronous, active-low reset
stall  input  1  pipeline stall; deasserts pcValid and holds the PC
halt  input  1  request to stop fetching
redirectValid  input  1  branch/jump redirect request
redirectTarget  input  XLEN  redirect target address
trapValid  input  1  trap/exception request
trapVector  input  XLEN  trap handler address
pcReady  input  1  instruction memory accepts pc
pcValid  output  1  fetch request valid
pc  output  XLEN  current fetch address (registered)
pcPlusStep  output  XLEN  combinational pc+STEP, used as link address
misalignErr  output  1  one-cycle pulse on a misaligned redirect
misalignAddr  output  XLEN  offending target, held until the next error
fetchCount  output  CNT_W  count of accepted fetches

Behaviour:
- Reset is asynchronous and active-low. resetN low immediately forces: pc=RESET_VECTOR, state=BOOT, pcValid=0, misalignErr=0, misalignAddr=0, fetchCount=0. This applies mid-operation too; any in-flight request is dropped.
- States (pc_state_t): BOOT, RUN, HALTED.
- BOOT: pcValid=0 for exactly one cycle after reset release, then RUN. Redirect, trap and halt are ignored in BOOT.
- RUN: pcValid = !stall. fire = pcValid & pcReady.
- Per-cycle priority in RUN, highest first:
  1. trapValid: pc <= trapVector with the alignment bits cleared; a concurrent fire is discarded (no count increment).
  2. redirectValid with aligned target: pc <= redirectTarget; fire is discarded.
  3. redirectValid with misaligned target: misalignErr=1 next cycle, misalignAddr <= target, pc unchanged, go to HALTED.
  4. halt: go to HALTED; pc unchanged; fire is discarded.
  5. fire: pc <= pc+STEP; fetchCount++.
  6. Otherwise hold.
- Valid/ready rule: while pcValid=1 and pcReady=0, pc stays stable. Only trap or redirect may change it.
- Stall holds pc and fetchCount. Trap and redirect are still honoured during a stall.
- HALTED: pcValid=0 and halt is ignored. Exits:
  - trap goes to RUN with pc=trapVector.
  - aligned redirect goes to RUN with pc=target.
  - misaligned redirect pulses the error again and stays in HALTED.
- Alignment: misaligned means target[1:0] != 0.
- Arithmetic: pc+STEP is modulo 2^XLEN, so 32'hFFFF_FFFC+4 = 0 with no flag. fetchCount wraps silently.
- Latency: a new pc is visible one cycle after a request, and pcValid is asserted that same cycle (RUN, no stall).

Optional Feature:
Macro PC_COMPRESSED_EN.
- Defined: adds input instrCompressed (1 bit). A fire with instrCompressed=1 advances by 2 instead of STEP. The alignment check uses only target[0]. Trap vectors have only bit 0 cleared.
- Undefined: the port is absent, the step is always STEP, and alignment uses bits [1:0].

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum pc_state_t {BOOT, RUN, HALTED}
  - localparam ALIGN_MASK_W (2, or 1 with PC_COMPRESSED_EN)
  - the default RESET_VECTOR constant
- One sub-module, pc_incrementer (params XLEN, STEP): combinational pc+step with an optional compressed select. Drives pcPlusStep and the next sequential pc.

Test Plan:
- Reset release with RESET_VECTOR=32'h100, pcReady=1 -> pcValid=0 for one cycle, then pc=32'h100, 32'h104, 32'h108, with fetchCount=1,2,3.
- pcReady=0 for 3 cycles at pc=32'h200 -> pc stays 32'h200, pcValid=1, fetchCount unchanged.
- pcReady=1, redirectValid=1, trapValid=1 with target 32'h400 and vector 32'h80 in one cycle -> pc=32'h80, fetchCount not incremented.
- Redirect to 32'h402 -> misalignErr pulses for 1 cycle, misalignAddr=32'h402, pcValid=0. Then redirect to 32'h500 -> RUN, pc=32'h500.
- pc=32'hFFFF_FFFC, fire -> pc=32'h0000_0000.
- resetN low mid-stall at pc=32'h300 -> pc=RESET_VECTOR and pcValid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
// Alignment width follows the PC_COMPRESSED_EN build option.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

`ifdef PC_COMPRESSED_EN
  localparam int unsigned ALIGN_MASK_W = 1;
`else
  localparam int unsigned ALIGN_MASK_W = 2;
`endif

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational next-sequential PC: pc + STEP, or pc + 2 for a compressed instruction.
module pc_incrementer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_compressed,
  output logic [XLEN-1:0] o_pc_next
);

  // Wraps modulo 2^XLEN by construction.
  assign o_pc_next = i_pc + (i_compressed ? XLEN'(2) : XLEN'(STEP));

endmodule

// File: rtl/pc_sequencer.sv
// Registered, handshaked PC sequencer with trap/redirect priority and misalign detection.
// Optional macro PC_COMPRESSED_EN adds instrCompressed and 2-byte alignment.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned          STEP         = 4,
  parameter int unsigned          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirectValid,
  input  logic [XLEN-1:0]  redirectTarget,
  input  logic             trapValid,
  input  logic [XLEN-1:0]  trapVector,
  input  logic             pcReady,
`ifdef PC_COMPRESSED_EN
  input  logic             instrCompressed,
`endif
  output logic             pcValid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pcPlusStep,
  output logic             misalignErr,
  output logic [XLEN-1:0]  misalignAddr,
  output logic [CNT_W-1:0] fetchCount
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((1 << ALIGN_MASK_W) - 1);

  pc_state_t        r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic [XLEN-1:0]  r_err_addr, w_err_addr_nxt;

  logic             w_compressed;
  logic             w_pc_valid;
  logic             w_fire;
  logic             w_misaligned;
  logic [XLEN-1:0]  w_pc_inc;
  logic [XLEN-1:0]  w_trap_pc;

`ifdef PC_COMPRESSED_EN
  assign w_compressed = instrCompressed;
`else
  assign w_compressed = 1'b0;
`endif

  pc_incrementer #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_inc (
    .i_pc         (r_pc),
    .i_compressed (w_compressed),
    .o_pc_next    (w_pc_inc)
  );

  assign w_pc_valid   = (r_state == RUN) && !stall;
  assign w_fire       = w_pc_valid && pcReady;
  assign w_misaligned = |(redirectTarget & ALIGN_MASK);
  assign w_trap_pc    = trapVector & ~ALIGN_MASK;

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_err_addr <= w_err_addr_nxt;
    end
  end

  // Next state: trap > aligned redirect > misaligned redirect > halt > fire.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = 1'b0;
    w_err_addr_nxt = r_err_addr;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (trapValid) begin
          w_pc_nxt = w_trap_pc;
        end else if (redirectValid && !w_misaligned) begin
          w_pc_nxt = redirectTarget;
        end else if (redirectValid) begin
          w_err_nxt      = 1'b1;
          w_err_addr_nxt = redirectTarget;
          w_state_nxt    = HALTED;
        end else if (halt) begin
          w_state_nxt = HALTED;
        end else if (w_fire) begin
          w_pc_nxt  = w_pc_inc;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HALTED: begin
        if (trapValid) begin
          w_pc_nxt    = w_trap_pc;
          w_state_nxt = RUN;
        end else if (redirectValid && !w_misaligned) begin
          w_pc_nxt    = redirectTarget;
          w_state_nxt = RUN;
        end else if (redirectValid) begin
          w_err_nxt      = 1'b1;
          w_err_addr_nxt = redirectTarget;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  assign pcValid      = w_pc_valid;
  assign pc           = r_pc;
  assign pcPlusStep   = w_pc_inc;
  assign misalignErr  = r_err;
  assign misalignAddr = r_err_addr;
  assign fetchCount   = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (RESET_VECTOR=32'h100, default build).
module tb_pc_sequencer;

  logic        clk;
  logic        resetN;
  logic        stall;
  logic        halt;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        trapValid;
  logic [31:0] trapVector;
  logic        pcReady;
  logic        pcValid;
  logic [31:0] pc;
  logic [31:0] pcPlusStep;
  logic        misalignErr;
  logic [31:0] misalignAddr;
  logic [31:0] fetchCount;

  pc_sequencer #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .STEP         (4),
    .CNT_W        (32)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .stall          (stall),
    .halt           (halt),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .trapValid      (trapValid),
    .trapVector     (trapVector),
    .pcReady        (pcReady),
    .pcValid        (pcValid),
    .pc             (pc),
    .pcPlusStep     (pcPlusStep),
    .misalignErr    (misalignErr),
    .misalignAddr   (misalignAddr),
    .fetchCount     (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        halt;
    logic        rv;
    logic [31:0] rt;
    logic        tv;
    logic [31:0] tvec;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic        eerr;
    logic [31:0] eaddr;
    logic [31:0] ecnt;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];
  int   n_vec;
  int   n_miss;

  function automatic vec_t mk(input logic st, input logic h, input logic rv, input logic [31:0] rt,
                              input logic tv, input logic [31:0] tvec, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic eerr,
                              input logic [31:0] eaddr, input logic [31:0] ecnt);
    vec_t v;
    v.stall = st; v.halt = h; v.rv = rv; v.rt = rt; v.tv = tv; v.tvec = tvec; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.eerr = eerr; v.eaddr = eaddr; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; halt = v.halt; redirectValid = v.rv; redirectTarget = v.rt;
    trapValid = v.tv; trapVector = v.tvec; pcReady = v.rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    resetN = 1'b0;
    stall = 1'b0; halt = 1'b0; redirectValid = 1'b0; redirectTarget = '0;
    trapValid = 1'b0; trapVector = '0; pcReady = 1'b1;

    // Expected values describe the cycle in which the inputs are applied (pre-edge).
    //              st h  rv rt            tv tvec          rdy ev epc           err addr          cnt
    vecs[0]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  0, 32'h100,      0, 32'h0,        0); // BOOT
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h100,      0, 32'h0,        0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h104,      0, 32'h0,        1);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h108,      0, 32'h0,        2);
    vecs[4]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h10C,      0, 32'h0,        3);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h10C,      0, 32'h0,        3);
    vecs[6]  = mk(1, 0, 0, 32'h0,        0, 32'h0,       1,  0, 32'h10C,      0, 32'h0,        3);
    vecs[7]  = mk(1, 0, 1, 32'h200,      0, 32'h0,       1,  0, 32'h10C,      0, 32'h0,        3);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h200,      0, 32'h0,        3);
    vecs[9]  = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h200,      0, 32'h0,        3);
    vecs[10] = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h200,      0, 32'h0,        3);
    vecs[11] = mk(0, 0, 1, 32'h400,      1, 32'h80,      1,  1, 32'h200,      0, 32'h0,        3);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h80,       0, 32'h0,        3);
    vecs[13] = mk(0, 0, 1, 32'h402,      0, 32'h0,       1,  1, 32'h84,       0, 32'h0,        4);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  0, 32'h84,       1, 32'h402,      4);
    vecs[15] = mk(0, 1, 0, 32'h0,        0, 32'h0,       1,  0, 32'h84,       0, 32'h402,      4);
    vecs[16] = mk(0, 0, 1, 32'h501,      0, 32'h0,       1,  0, 32'h84,       0, 32'h402,      4);
    vecs[17] = mk(0, 0, 1, 32'h500,      0, 32'h0,       1,  0, 32'h84,       1, 32'h501,      4);
    vecs[18] = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h500,      0, 32'h501,      4);
    vecs[19] = mk(0, 1, 0, 32'h0,        0, 32'h0,       1,  1, 32'h504,      0, 32'h501,      5);
    vecs[20] = mk(0, 0, 0, 32'h0,        1, 32'h8B,      1,  0, 32'h504,      0, 32'h501,      5);
    vecs[21] = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'h88,       0, 32'h501,      5);
    vecs[22] = mk(1, 0, 0, 32'h0,        1, 32'h33,      1,  0, 32'h8C,       0, 32'h501,      6);
    vecs[23] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,      1,  1, 32'h30,       0, 32'h501,      6);
    vecs[24] = mk(0, 0, 0, 32'h0,        0, 32'h0,       1,  1, 32'hFFFF_FFFC, 0, 32'h501,     6);
    vecs[25] = mk(0, 0, 0, 32'h0,        0, 32'h0,       0,  1, 32'h0,        0, 32'h501,      7);

    // Reset state while held.
    #12;
    chk("rst.pc", pc, 32'h100);
    chk("rst.valid", 32'(pcValid), 32'h0);
    chk("rst.cnt", fetchCount, 32'h0);
    chk("rst.err", 32'(misalignErr), 32'h0);
    chk("rst.addr", misalignAddr, 32'h0);
    next_cycle();
    resetN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      chk($sformatf("v%0d.valid", i), 32'(pcValid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.pc", i), pc, vecs[i].epc);
      chk($sformatf("v%0d.pcPlusStep", i), pcPlusStep, vecs[i].epc + 32'd4);
      chk($sformatf("v%0d.err", i), 32'(misalignErr), 32'(vecs[i].eerr));
      chk($sformatf("v%0d.addr", i), misalignAddr, vecs[i].eaddr);
      chk($sformatf("v%0d.cnt", i), fetchCount, vecs[i].ecnt);
      next_cycle();
    end

    // Asynchronous reset asserted mid-stall at pc=0x300, checked before any clock edge.
    stall = 1'b0; halt = 1'b0; trapValid = 1'b0; pcReady = 1'b0;
    redirectValid = 1'b1; redirectTarget = 32'h300;
    next_cycle();
    redirectValid = 1'b0; stall = 1'b1;
    #1;
    chk("stall.pc", pc, 32'h300);
    chk("stall.valid", 32'(pcValid), 32'h0);
    #1;
    resetN = 1'b0;
    #1;
    chk("async.pc", pc, 32'h100);
    chk("async.valid", 32'(pcValid), 32'h0);
    chk("async.cnt", fetchCount, 32'h0);
    chk("async.addr", misalignAddr, 32'h0);
    next_cycle();
    stall = 1'b0; pcReady = 1'b1;
    resetN = 1'b1;
    #2;
    chk("reboot.valid", 32'(pcValid), 32'h0);
    next_cycle();
    chk("rerun.valid", 32'(pcValid), 32'h1);
    chk("rerun.pc", pc, 32'h100);
    next_cycle();
    chk("rerun.pc2", pc, 32'h104);
    chk("rerun.cnt", fetchCount, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
